// File: rtl/sfx_audio_scheduler.sv
// Beat-rate scheduler sharing the note_gen tone path between music and three
// gameplay sound effects (jump, land, bump) with priority, queueing and preemption.
//
// state | meaning
// IDLE  | music passes through, waiting for a pending effect
// PLAY  | effect notes are driven, STEP_LEN cycles per note
// GAP   | silence between back-to-back effects, GAP_LEN cycles
module sfx_audio_scheduler #(
    parameter int          STEP_LEN = 2,
    parameter int          GAP_LEN  = 1,
    parameter logic [31:0] SILENCE  = 32'd50_000_000,
    parameter int          MIX_MODE = 0
) (
    input  logic        clk22,
    input  logic        rst,
    input  logic        music_en,
    input  logic [31:0] bgm_toneL,
    input  logic [31:0] bgm_toneR,
    input  logic [2:0]  sfx_req,
    output logic [31:0] toneL,
    output logic [31:0] toneR,
    output logic        beat_hold,
    output logic        sfx_busy,
    output logic [1:0]  sfx_id
);

    localparam logic [3:0] STEP_LAST = 4'(STEP_LEN - 1);
    localparam logic [1:0] GAP_LAST  = 2'((GAP_LEN == 0) ? 0 : GAP_LEN - 1);
    localparam bit         HAS_GAP   = (GAP_LEN > 0);
    localparam bit         MIX       = (MIX_MODE != 0);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t      state, state_n;
    logic [2:0]  req_s1, req_s2, req_s3;
    logic [2:0]  req_rise;
    logic [2:0]  pend, pend_clr;
    logic [1:0]  cur_id, cur_n;
    logic [1:0]  note_idx, note_n;
    logic [3:0]  step_cnt, step_n;
    logic [1:0]  gap_cnt, gap_n;
    logic [1:0]  hi_id;
    logic        launch;
    logic [31:0] fx_tone, music_l, music_r;
    logic [31:0] tone_l_n, tone_r_n;

    function automatic logic [31:0] fx_note(input logic [1:0] id, input logic [1:0] idx);
        logic [31:0] t;
        t = SILENCE;
        case (id)
            2'd1: case (idx)
                2'd0:    t = 32'd523;
                2'd1:    t = 32'd659;
                2'd2:    t = 32'd784;
                default: t = 32'd1047;
            endcase
            2'd2: t = (idx == 2'd0) ? 32'd196 : 32'd131;
            2'd3: t = (idx == 2'd2) ? SILENCE : 32'd110;
            default: t = SILENCE;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] fx_last(input logic [1:0] id);
        logic [1:0] n;
        case (id)
            2'd1:    n = 2'd3;
            2'd2:    n = 2'd1;
            2'd3:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // sfx_req is asynchronous: two flops for metastability, a third for edge detect
    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            req_s1 <= 3'b000;
            req_s2 <= 3'b000;
            req_s3 <= 3'b000;
        end else begin
            req_s1 <= sfx_req;
            req_s2 <= req_s1;
            req_s3 <= req_s2;
        end
    end

    assign req_rise = req_s2 & ~req_s3;

    always_comb begin
        hi_id = 2'd0;
        if (pend[2])      hi_id = 2'd3;
        else if (pend[1]) hi_id = 2'd2;
        else if (pend[0]) hi_id = 2'd1;
    end

    always_comb begin
        state_n = state;
        cur_n   = cur_id;
        note_n  = note_idx;
        step_n  = step_cnt;
        gap_n   = gap_cnt;
        launch  = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend != 3'b000) launch = 1'b1;
            end
            S_PLAY: begin
                // cur_id is non-zero here, so a larger id means strictly higher priority
                if (hi_id > cur_id) begin
                    launch = 1'b1;
                end else if (step_cnt == STEP_LAST) begin
                    if (note_idx == fx_last(cur_id)) begin
                        if (pend == 3'b000) begin
                            state_n = S_IDLE;
                            cur_n   = 2'd0;
                        end else if (HAS_GAP) begin
                            state_n = S_GAP;
                            gap_n   = 2'd0;
                            cur_n   = 2'd0;
                        end else begin
                            launch = 1'b1;
                        end
                    end else begin
                        note_n = note_idx + 2'd1;
                        step_n = 4'd0;
                    end
                end else begin
                    step_n = step_cnt + 4'd1;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (pend != 3'b000) begin
                        launch = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        cur_n   = 2'd0;
                    end
                end else begin
                    gap_n = gap_cnt + 2'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cur_n   = 2'd0;
            end
        endcase
        if (launch) begin
            state_n = S_PLAY;
            cur_n   = hi_id;
            note_n  = 2'd0;
            step_n  = 4'd0;
        end
    end

    always_comb begin
        pend_clr = 3'b000;
        if (launch) begin
            case (hi_id)
                2'd1:    pend_clr = 3'b001;
                2'd2:    pend_clr = 3'b010;
                2'd3:    pend_clr = 3'b100;
                default: pend_clr = 3'b000;
            endcase
        end
    end

    always_comb begin
        fx_tone  = fx_note(cur_n, note_n);
        music_l  = music_en ? bgm_toneL : SILENCE;
        music_r  = music_en ? bgm_toneR : SILENCE;
        tone_l_n = music_l;
        tone_r_n = music_r;
        case (state_n)
            S_PLAY: begin
                tone_l_n = fx_tone;
                tone_r_n = MIX ? music_r : fx_tone;
            end
            S_GAP: begin
                tone_l_n = SILENCE;
                tone_r_n = SILENCE;
            end
            default: begin
                tone_l_n = music_l;
                tone_r_n = music_r;
            end
        endcase
    end

    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cur_id    <= 2'd0;
            note_idx  <= 2'd0;
            step_cnt  <= 4'd0;
            gap_cnt   <= 2'd0;
            pend      <= 3'b000;
            toneL     <= SILENCE;
            toneR     <= SILENCE;
            beat_hold <= 1'b0;
            sfx_busy  <= 1'b0;
            sfx_id    <= 2'd0;
        end else begin
            state     <= state_n;
            cur_id    <= cur_n;
            note_idx  <= note_n;
            step_cnt  <= step_n;
            gap_cnt   <= gap_n;
            // a new edge wins over the launch clear so it is never lost
            pend      <= (pend & ~pend_clr) | req_rise;
            toneL     <= tone_l_n;
            toneR     <= tone_r_n;
            beat_hold <= !MIX && (state_n != S_IDLE);
            sfx_busy  <= (state_n != S_IDLE);
            sfx_id    <= (state_n == S_PLAY) ? cur_n : 2'd0;
        end
    end

endmodule

// File: tb/tb_sfx_audio_scheduler.sv
// Directed bench for sfx_audio_scheduler: default instance plus a MIX_MODE=1 instance
// fed from the same stimulus, checked against hand-computed tone sequences.
module tb_sfx_audio_scheduler;

    localparam logic [31:0] SIL = 32'd50_000_000;

    logic        clk22 = 1'b0;
    logic        rst = 1'b1;
    logic        music_en = 1'b1;
    logic [31:0] bgm_toneL = 32'd262;
    logic [31:0] bgm_toneR = 32'd294;
    logic [2:0]  sfx_req = 3'b000;

    logic [31:0] toneL, toneR, m_toneL, m_toneR;
    logic        beat_hold, sfx_busy, m_beat_hold, m_sfx_busy;
    logic [1:0]  sfx_id, m_sfx_id;

    int n_chk = 0;
    int n_err = 0;
    int land_cnt = 0;
    logic [1:0] prev_id = 2'd0;

    sfx_audio_scheduler u_dut (
        .clk22(clk22), .rst(rst), .music_en(music_en),
        .bgm_toneL(bgm_toneL), .bgm_toneR(bgm_toneR), .sfx_req(sfx_req),
        .toneL(toneL), .toneR(toneR), .beat_hold(beat_hold),
        .sfx_busy(sfx_busy), .sfx_id(sfx_id)
    );

    sfx_audio_scheduler #(.MIX_MODE(1)) u_mix (
        .clk22(clk22), .rst(rst), .music_en(music_en),
        .bgm_toneL(bgm_toneL), .bgm_toneR(bgm_toneR), .sfx_req(sfx_req),
        .toneL(m_toneL), .toneR(m_toneR), .beat_hold(m_beat_hold),
        .sfx_busy(m_sfx_busy), .sfx_id(m_sfx_id)
    );

    always #5 clk22 = ~clk22;

    always @(posedge clk22) begin
        #2;
        if (sfx_id == 2'd2 && prev_id != 2'd2) land_cnt++;
        prev_id = sfx_id;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk22);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [31:0] jump_seq [8] = '{32'd523, 32'd523, 32'd659, 32'd659,
                                  32'd784, 32'd784, 32'd1047, 32'd1047};
    logic [31:0] dual_seq [13] = '{32'd196, 32'd196, 32'd131, 32'd131, SIL,
                                   32'd523, 32'd523, 32'd659, 32'd659,
                                   32'd784, 32'd784, 32'd1047, 32'd1047};
    logic [31:0] pre_seq [10] = '{32'd659, 32'd784, 32'd784, 32'd110, 32'd110,
                                  32'd110, 32'd110, SIL, SIL, 32'd262};
    logic [2:0]  dup_stim [15] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b010,
                                   3'b000, 3'b000, 3'b010, 3'b010, 3'b000,
                                   3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [31:0] dup_seq [12] = '{32'd110, 32'd110, 32'd110, 32'd110, SIL, SIL,
                                  SIL, 32'd196, 32'd196, 32'd131, 32'd131, 32'd262};
    logic [31:0] mix_seq [7] = '{32'd110, 32'd110, 32'd110, 32'd110, SIL, SIL, 32'd262};

    int lands_before;

    initial begin
        // reset and idle passthrough
        idle(3);
        chk("rst_toneL", toneL, SIL);
        chk("rst_toneR", toneR, SIL);
        chk("rst_hold", 32'(beat_hold), 32'd0);
        chk("rst_busy", 32'(sfx_busy), 32'd0);
        chk("rst_id", 32'(sfx_id), 32'd0);
        chk("rst_mix_toneR", m_toneR, SIL);
        rst = 1'b0;
        tick();
        chk("idle_toneL", toneL, 32'd262);
        chk("idle_toneR", toneR, 32'd294);
        chk("idle_hold", 32'(beat_hold), 32'd0);
        music_en = 1'b0;
        tick();
        chk("mute_toneL", toneL, SIL);
        chk("mute_toneR", toneR, SIL);
        music_en = 1'b1;
        idle(3);

        // single jump, pulse 3 cycles
        sfx_req = 3'b001;
        idle(3);
        sfx_req = 3'b000;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("jump_toneL", toneL, jump_seq[i]);
            chk("jump_hold", 32'(beat_hold), 32'd1);
            chk("jump_id", 32'(sfx_id), 32'd1);
        end
        tick();
        chk("jump_end_toneL", toneL, 32'd262);
        chk("jump_end_hold", 32'(beat_hold), 32'd0);
        chk("jump_end_busy", 32'(sfx_busy), 32'd0);
        idle(4);

        // jump and land together: land, one gap cycle, then jump
        sfx_req = 3'b011;
        idle(3);
        sfx_req = 3'b000;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk("dual_toneL", toneL, dual_seq[i]);
            chk("dual_busy", 32'(sfx_busy), 32'd1);
        end
        chk("dual_last_id", 32'(sfx_id), 32'd1);
        tick();
        chk("dual_end_busy", 32'(sfx_busy), 32'd0);
        idle(4);

        // bump preempts jump on note 1
        sfx_req = 3'b001;
        idle(3);
        sfx_req = 3'b000;
        idle(3);
        chk("pre_jump_n1", toneL, 32'd659);
        sfx_req = 3'b100;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 2) sfx_req = 3'b000;
            chk("pre_toneL", toneL, pre_seq[i]);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("pre_no_resume", 32'(sfx_busy), 32'd0);
        end

        // land held high for 40 cycles plays exactly once
        lands_before = land_cnt;
        sfx_req = 3'b010;
        idle(4);
        chk("hold_first", toneL, 32'd196);
        idle(36);
        sfx_req = 3'b000;
        idle(8);
        chk("hold_once", 32'(land_cnt - lands_before), 32'd1);
        chk("hold_idle", 32'(sfx_busy), 32'd0);

        // two land edges while bump plays queue a single land
        lands_before = land_cnt;
        for (int i = 0; i < 15; i++) begin
            sfx_req = dup_stim[i];
            tick();
            if (i >= 3) begin
                chk("dup_toneL", toneL, dup_seq[i-3]);
                chk("dup_busy", 32'(sfx_busy), (i < 14) ? 32'd1 : 32'd0);
            end
        end
        idle(10);
        chk("dup_one_land", 32'(land_cnt - lands_before), 32'd1);

        // MIX_MODE=1 instance: effect on left only, music kept on right
        bgm_toneR = 32'd330;
        idle(2);
        sfx_req = 3'b100;
        idle(3);
        sfx_req = 3'b000;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("mix_toneL", m_toneL, mix_seq[i]);
            chk("mix_toneR", m_toneR, 32'd330);
            chk("mix_hold", 32'(m_beat_hold), 32'd0);
            chk("mix_busy", 32'(m_sfx_busy), (i < 6) ? 32'd1 : 32'd0);
        end

        // reset mid-effect aborts immediately
        sfx_req = 3'b001;
        idle(3);
        sfx_req = 3'b000;
        idle(2);
        chk("mid_playing", 32'(sfx_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_toneL", toneL, SIL);
        chk("mid_rst_busy", 32'(sfx_busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rel_toneL", toneL, 32'd262);
        idle(12);
        chk("mid_no_restart", 32'(sfx_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sfx_audio_scheduler.md
# sfx_audio_scheduler

Beat-rate scheduler that shares the single `note_gen` audio path between background music and three gameplay sound effects (jump, land, wall bump). It sits between `music_wii` and the `50000000 / tone` divider feeding `note_gen`. It plays the built-in effect note sequences, arbitrates and queues effect requests, and freezes the music beat counter while an effect owns the speaker. Everything runs on the beat clock `clk22` (100 MHz / 2^22, ≈23.8 Hz).

## Interface
Parameters:
- `STEP_LEN`, default 2: clk22 cycles per effect note, legal range 1–15.
- `GAP_LEN`, default 1: silent clk22 cycles between back-to-back effects, legal range 0–3.
- `SILENCE`, default 32'd50_000_000: tone value meaning silence (divider output 1).
- `MIX_MODE`, default 0: 0 = the effect drives both channels; 1 = the effect drives the left channel only and the right channel keeps music.

Ports:
- `clk22` — in, 1: beat clock.
- `rst` — in, 1: reset, asynchronous, active-high.
- `music_en` — in, 1: music enabled.
- `bgm_toneL` — in, 32: music tone, left channel.
- `bgm_toneR` — in, 32: music tone, right channel.
- `sfx_req` — in, 3: request levels, bit0 jump, bit1 land, bit2 bump. Asynchronous to clk22 and held at least 2 clk22 cycles.
- `toneL` — out, 32: scheduled tone, left channel (registered).
- `toneR` — out, 32: scheduled tone, right channel (registered).
- `beat_hold` — out, 1: 1 = the music beat counter must not advance.
- `sfx_busy` — out, 1: an effect is in PLAY or GAP.
- `sfx_id` — out, 2: effect currently playing. 0 none, 1 jump, 2 land, 3 bump.

## Operation
- **Input sync:** each `sfx_req` bit passes through a 2-flop synchroniser and a rising-edge detector. One edge produces one request. A level held high never re-triggers.
- **Pending:** `pend[2:0]`, one bit per effect.
  - Set by an edge.
  - Cleared when that effect is launched.
  - An edge for an already-pending effect is absorbed.
- **Priority:** bump (bit2) > land (bit1) > jump (bit0). Among pending bits, the highest wins.
- **Effect ROM** (tone sequence, in notes):
  - jump: 523, 659, 784, 1047 (4 notes).
  - land: 196, 131 (2 notes).
  - bump: 110, 110, SILENCE (3 notes).
- **FSM states:** IDLE, PLAY, GAP.
  - IDLE → PLAY when `pend != 0`. Launch the highest-priority pending effect at note 0, step counter 0.
  - PLAY: the step counter counts 0..STEP_LEN−1, then the note index advances.
  - After the last note completes: go to GAP if `GAP_LEN > 0` and `pend != 0`; otherwise go to IDLE. With `GAP_LEN = 0` and `pend != 0`, go directly to PLAY with the next effect.
  - GAP lasts GAP_LEN cycles, then → PLAY if `pend != 0`, else → IDLE.
- **Preemption:** in PLAY, a pending effect of strictly higher priority than `sfx_id` aborts the current effect on the next edge and restarts PLAY with the new effect at note 0. No gap is inserted. The aborted effect is dropped, not re-queued.
- **Output select** (registered from next-state values):
  - IDLE: `toneL/toneR` = `music_en ? bgm_toneL/R : SILENCE`.
  - PLAY, MIX_MODE 0: both channels = effect note.
  - PLAY, MIX_MODE 1: `toneL` = effect note; `toneR` = `music_en ? bgm_toneR : SILENCE`.
  - GAP: both channels = SILENCE.
- **beat_hold** = 1 in PLAY and GAP when MIX_MODE = 0; 0 in every state when MIX_MODE = 1.
- **sfx_busy** = 1 in PLAY and GAP. **sfx_id** = current effect in PLAY, 0 otherwise.

## Timing
- **Reset values:** `toneL = toneR = SILENCE`, `beat_hold = 0`, `sfx_busy = 0`, `sfx_id = 0`, `pend = 0`, synchronisers 0, FSM in IDLE.
- Reset asserted mid-effect aborts immediately. After release, the first output is the IDLE mux result at the first clk22 edge.
- **Request latency:** a `sfx_req` rise before edge E appears on outputs after edge E+3. Edges E+1 and E+2 are the synchroniser, E+2 sets pend, E+3 enters PLAY with the note registered.
- Each note is held exactly STEP_LEN cycles. Effect duration = notes × STEP_LEN cycles.
- **Passthrough:** in IDLE, `bgm_tone` reaches `toneL/R` with 1 cycle of latency.
- A pend edge that arrives on the same cycle as the last note's final step is seen by that cycle's transition decision.
- Two bits rising together set both pend bits. The higher priority plays first; the other follows after GAP.

## Test plan
1. **Reset/idle:** assert rst, then release with `music_en = 1` and `bgm_toneL = 262`.
   - During reset, outputs = 50_000_000.
   - One cycle after release, `toneL = 262`, `beat_hold = 0`.
2. **Single jump:** pulse bit0 for 3 cycles with defaults.
   - `toneL` = 523, 523, 659, 659, 784, 784, 1047, 1047, starting at edge E+3.
   - `beat_hold = 1` for 8 cycles, then music resumes. `sfx_id` = 1 throughout.
3. **Simultaneous request:** raise bit0 and bit1 in the same cycle.
   - Land plays (196×2, 131×2), then 1 SILENCE cycle, then the jump sequence.
   - `sfx_busy` stays high for 13 contiguous cycles.
4. **Preemption:** raise bit2 while jump is on note 1.
   - Jump aborts. `toneL = 110` appears 3 edges after the bit2 rise.
   - Bump completes, then IDLE. Jump does not resume.
5. **Held level and duplicate:** hold bit1 high for 40 cycles.
   - Exactly one land effect plays.
   - A second bit1 edge during PLAY queues one more land; a third edge in the same window adds nothing.
6. **MIX_MODE = 1:** bump with `music_en = 1`, `bgm_toneR = 330`.
   - `toneL` = 110, 110, 110, 110, SIL, SIL.
   - `toneR = 330` throughout; `beat_hold = 0` throughout.
